// File: rtl/counter_defs.sv
// counter_defs: shared direction, mode and prescaler constants for the modulo counter family
package counter_defs;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DOWN = 1'b0;
  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT = 1;
  localparam int PRESC_W = 16;
endpackage

// File: rtl/tick_divider.sv
// tick_divider: emits one tick every PRESCALE enabled cycles; clear restarts the count
module tick_divider
  import counter_defs::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);
  logic [PRESC_W-1:0] cnt;
  assign tick = enable && (cnt == PRESC_W'(PRESCALE - 1));
  always_ff @(posedge clock)
    if (reset || clear || tick) cnt <= '0;
    else if (enable) cnt <= cnt + PRESC_W'(1);
endmodule

// File: rtl/modcounter.sv
// modcounter: prescaled up/down modulo counter with load, wrap/saturate ends and cascade carry
module modcounter
  import counter_defs::*;
#(
  parameter int WIDTH    = 8,
  parameter int MODULUS  = 256,
  parameter int PRESCALE = 1,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] iLoadValue,
  input  logic             clear_flag,
  output logic [WIDTH-1:0] oResult,
  output logic             oTerminal,
  output logic             oCarry,
  output logic             oWrap,
  output logic             oOverflow
);
  localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);
  // one extra bit so MODULUS = 2^WIDTH is representable for the load clamp
  localparam logic [WIDTH:0] MOD = (WIDTH + 1)'(MODULUS);
  if (MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_modulus
    $error("modcounter: MODULUS out of range");
  end
  if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
    $error("modcounter: PRESCALE out of range");
  end
  logic tick, wrap_set;
  logic [WIDTH-1:0] ld_val, step;
  tick_divider #(.PRESCALE(PRESCALE)) u_div (
    .clock (clock),
    .reset (reset),
    .enable(enable),
    .clear (load),
    .tick  (tick)
  );
  // away from a bound the step never leaves 0..MODULUS-1, so WIDTH bits suffice
  always_comb begin
    oTerminal = (up == DIR_UP) ? (oResult == TOP) : (oResult == '0);
    oCarry = tick && oTerminal;
    wrap_set = oCarry && !load;
    ld_val = ({1'b0, iLoadValue} >= MOD) ? TOP : iLoadValue;
    step = !oTerminal ? ((up == DIR_UP) ? oResult + WIDTH'(1) : oResult - WIDTH'(1))
         : (SATURATE == MODE_SAT) ? oResult
         : (up == DIR_UP) ? '0 : TOP;
  end
  always_ff @(posedge clock)
    if (reset) begin
      oResult <= '0;
      oWrap <= 1'b0;
      oOverflow <= 1'b0;
    end else begin
      oWrap <= wrap_set;
      oOverflow <= wrap_set || (oOverflow && !clear_flag);
      if (load) oResult <= ld_val;
      else if (tick) oResult <= step;
    end
endmodule

// File: tb/tb_modcounter.sv
// tb_modcounter: directed and random checks of three counter configurations plus a two-digit cascade
module tb_modcounter;
  localparam int MM [3] = '{10, 10, 256};
  localparam int PP [3] = '{1, 1, 3};
  localparam int SS [3] = '{0, 1, 0};
  localparam int WW [3] = '{4, 4, 8};
  logic clock = 1'b0;
  logic reset, enable, up, load, clear_flag, ce;
  logic [7:0] lv;
  logic [3:0] ra, rs, rlo, rhi;
  logic [7:0] rp;
  logic ta, ca, wa, oa, ts, cs, ws, os, tp, cp, wp, op;
  logic tlo, clo, wlo, olo, thi, chi, whi, ohi;
  int n_asrt = 0, n_fail = 0, ncyc = 0;
  int mc [3], mp [3], mw [3], mo [3];
  int mlo, mhi;
  always #5 clock = ~clock;
  modcounter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .SATURATE(0)) u_a (
    .clock(clock), .reset(reset), .enable(enable), .up(up), .load(load),
    .iLoadValue(lv[3:0]), .clear_flag(clear_flag), .oResult(ra), .oTerminal(ta),
    .oCarry(ca), .oWrap(wa), .oOverflow(oa));
  modcounter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .SATURATE(1)) u_s (
    .clock(clock), .reset(reset), .enable(enable), .up(up), .load(load),
    .iLoadValue(lv[3:0]), .clear_flag(clear_flag), .oResult(rs), .oTerminal(ts),
    .oCarry(cs), .oWrap(ws), .oOverflow(os));
  modcounter #(.WIDTH(8), .MODULUS(256), .PRESCALE(3), .SATURATE(0)) u_p (
    .clock(clock), .reset(reset), .enable(enable), .up(up), .load(load),
    .iLoadValue(lv), .clear_flag(clear_flag), .oResult(rp), .oTerminal(tp),
    .oCarry(cp), .oWrap(wp), .oOverflow(op));
  modcounter #(.WIDTH(4), .MODULUS(10)) u_lo (
    .clock(clock), .reset(reset), .enable(ce), .up(1'b1), .load(1'b0),
    .iLoadValue(4'd0), .clear_flag(1'b0), .oResult(rlo), .oTerminal(tlo),
    .oCarry(clo), .oWrap(wlo), .oOverflow(olo));
  modcounter #(.WIDTH(4), .MODULUS(10)) u_hi (
    .clock(clock), .reset(reset), .enable(clo), .up(1'b1), .load(1'b0),
    .iLoadValue(4'd0), .clear_flag(1'b0), .oResult(rhi), .oTerminal(thi),
    .oCarry(chi), .oWrap(whi), .oOverflow(ohi));

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] obs(int i, int k);
    logic [7:0] r = i == 0 ? {4'd0, ra} : i == 1 ? {4'd0, rs} : rp;
    logic [4:0] f = i == 0 ? 5'(ta) : i == 1 ? 5'(ts) : 5'(tp);
    f = {(i == 0 ? wa : i == 1 ? ws : wp), (i == 0 ? oa : i == 1 ? os : op),
         (i == 0 ? ca : i == 1 ? cs : cp), 1'b0, f[0]};
    return k == 0 ? 32'(r) : 32'(f[k - 1]);
  endfunction

  task automatic cyc();
    int tk, bnd, lvv;
    #1;
    for (int i = 0; i < 3; i++) begin
      tk = int'(enable && mp[i] == PP[i] - 1);
      bnd = up ? int'(mc[i] == MM[i] - 1) : int'(mc[i] == 0);
      chk($sformatf("term%0d", i), obs(i, 1), bnd);
      chk($sformatf("carry%0d", i), obs(i, 3), tk & bnd);
      if (reset) begin
        mc[i] = 0; mp[i] = 0; mw[i] = 0; mo[i] = 0;
      end else if (load) begin
        lvv = int'(lv) % (1 << WW[i]);
        mc[i] = lvv >= MM[i] ? MM[i] - 1 : lvv;
        mp[i] = 0; mw[i] = 0;
        mo[i] = int'(mo[i] != 0 && !clear_flag);
      end else begin
        mw[i] = tk & bnd;
        if (tk != 0 && !(bnd != 0 && SS[i] != 0))
          mc[i] = up ? (mc[i] + 1) % MM[i] : (mc[i] + MM[i] - 1) % MM[i];
        if (enable) mp[i] = (mp[i] + 1) % PP[i];
        mo[i] = int'(mw[i] != 0 || (mo[i] != 0 && !clear_flag));
      end
    end
    chk("lo_carry", 32'(clo), 32'(ce && mlo == 9));
    if (reset) begin
      mlo = 0; mhi = 0;
    end else if (ce) begin
      if (mlo == 9) mhi = (mhi + 1) % 10;
      mlo = (mlo + 1) % 10;
    end
    @(posedge clock);
    #1;
    ncyc++;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("res%0d", i), obs(i, 0), mc[i]);
      chk($sformatf("wrap%0d", i), obs(i, 5), mw[i]);
      chk($sformatf("ovf%0d", i), obs(i, 4), mo[i]);
    end
    chk("lo_res", 32'(rlo), mlo);
    chk("hi_res", 32'(rhi), mhi);
  endtask

  initial begin
    int nwa, nws, t1;
    reset = 1; enable = 0; up = 1; load = 0; lv = 0; clear_flag = 0; ce = 0;
    cyc(); cyc();
    chk("rst_res", 32'(ra), 0);
    chk("rst_ovf", 32'(oa), 0);
    reset = 0;
    enable = 1; nwa = 0;
    repeat (12) begin cyc(); nwa += int'(wa); end
    chk("wrapup_res", 32'(ra), 2);
    chk("wrapup_nwrap", nwa, 1);
    chk("wrapup_ovf", 32'(oa), 1);
    load = 1; lv = 2; cyc();
    load = 0; up = 0; nws = 0;
    repeat (4) begin cyc(); nws += int'(ws); end
    chk("satdn_res", 32'(rs), 0);
    chk("satdn_nwrap", nws, 2);
    up = 1; load = 1; lv = 12; cyc();
    chk("clamp_res", 32'(ra), 9);
    chk("clamp_wide", 32'(rp), 12);
    reset = 1; lv = 5; cyc();
    chk("rstld_res", 32'(ra), 0);
    reset = 0; enable = 0; lv = 9; cyc();
    load = 0; enable = 1; clear_flag = 1; cyc();
    chk("race_wrap", 32'(wa), 1);
    chk("race_ovf", 32'(oa), 1);
    enable = 0; cyc();
    chk("clr_ovf", 32'(oa), 0);
    clear_flag = 0; reset = 1; cyc();
    reset = 0; enable = 1;
    repeat (3) cyc();
    chk("pre_step1", 32'(rp), 1);
    t1 = ncyc;
    cyc();
    enable = 0; cyc(); cyc();
    enable = 1; cyc();
    chk("pre_hold", 32'(rp), 1);
    cyc();
    chk("pre_step2", 32'(rp), 2);
    chk("pre_interval", ncyc - t1, 5);
    repeat (400) begin
      reset = ($urandom % 50) == 0;
      enable = ($urandom % 4) != 0;
      up = ($urandom % 4) != 0;
      load = ($urandom % 20) == 0;
      lv = 8'($urandom);
      clear_flag = ($urandom % 8) == 0;
      cyc();
    end
    reset = 1; enable = 0; load = 0; clear_flag = 0; up = 1; cyc();
    reset = 0; ce = 1;
    repeat (99) cyc();
    chk("casc_99", 32'(rhi) * 10 + 32'(rlo), 99);
    cyc();
    chk("casc_lo0", 32'(rlo), 0);
    chk("casc_hi0", 32'(rhi), 0);
    chk("casc_lo_wrap", 32'(wlo), 1);
    chk("casc_hi_wrap", 32'(whi), 1);
    ce = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
